// File: rtl/mipsfpga_ahb_master_mux.sv
// Two-master AHB-Lite bus mux: address/control by address-phase owner, write data and
// response by data-phase owner, with per-master transfer counters, stall and lock monitors.
module mipsfpga_ahb_master_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [3:0]        HMASTER,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [ADDR_W-1:0] M0_HADDR,
  input  logic [1:0]        M0_HTRANS,
  input  logic              M0_HWRITE,
  input  logic [2:0]        M0_HSIZE,
  input  logic [2:0]        M0_HBURST,
  input  logic [DATA_W-1:0] M0_HWDATA,
  input  logic [ADDR_W-1:0] M1_HADDR,
  input  logic [1:0]        M1_HTRANS,
  input  logic              M1_HWRITE,
  input  logic [2:0]        M1_HSIZE,
  input  logic [2:0]        M1_HBURST,
  input  logic [DATA_W-1:0] M1_HWDATA,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  output logic [1:0]        M0_HRESP,
  output logic [1:0]        M1_HRESP,
  output logic [CNT_W-1:0]  M0_XFER_CNT,
  output logic [CNT_W-1:0]  M1_XFER_CNT,
  input  logic              CNT_CLR,
  output logic              STALL_FLAG,
  output logic              LOCK_VIOL,
  input  logic              FLAG_CLR
);

  typedef enum logic [1:0] {D_IDLE = 2'd0, D_M0 = 2'd1, D_M1 = 2'd2} dph_state_t;
  typedef enum logic [1:0] {OWN_M0 = 2'd0, OWN_M1 = 2'd1, OWN_NONE = 2'd2} dph_own_t;

  localparam int              WAIT_W    = 12;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  dph_state_t        dph_state_q, dph_state_d;
  dph_own_t          dph_own_q, dph_own_d;
  logic [3:0]        prev_master_q, prev_master_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              stall_q, stall_d;
  logic              lock_q, lock_d;
  logic              dph_valid_s;
  logic              stall_set_s;
  logic              lock_set_s;

  assign dph_valid_s = (dph_state_q != D_IDLE);

  // Address-phase mux; unknown owner behaves as an idle default master.
  always_comb begin
    HADDR  = '0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
    HBURST = 3'd0;
    case (HMASTER)
      4'd0: begin
        HADDR  = M0_HADDR;
        HTRANS = M0_HTRANS;
        HWRITE = M0_HWRITE;
        HSIZE  = M0_HSIZE;
        HBURST = M0_HBURST;
      end
      4'd1: begin
        HADDR  = M1_HADDR;
        HTRANS = M1_HTRANS;
        HWRITE = M1_HWRITE;
        HSIZE  = M1_HSIZE;
        HBURST = M1_HBURST;
      end
      default: begin
        HADDR  = '0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HBURST = 3'd0;
      end
    endcase
  end

  // Data-phase write data and response routing follow the registered owner.
  always_comb begin
    HWDATA   = '0;
    M0_HRESP = 2'b00;
    M1_HRESP = 2'b00;
    case (dph_own_q)
      OWN_M0:  HWDATA = M0_HWDATA;
      OWN_M1:  HWDATA = M1_HWDATA;
      default: HWDATA = '0;
    endcase
    if (dph_state_q == D_M0) begin
      M0_HRESP = HRESP;
    end else if (dph_state_q == D_M1) begin
      M1_HRESP = HRESP;
    end else begin
      M0_HRESP = 2'b00;
      M1_HRESP = 2'b00;
    end
  end

  // Data-phase tracker: advances only on HREADY-qualified cycles.
  always_comb begin
    dph_state_d   = dph_state_q;
    dph_own_d     = dph_own_q;
    prev_master_d = prev_master_q;
    if (HREADY) begin
      prev_master_d = HMASTER;
      case (HMASTER)
        4'd0: begin
          dph_own_d   = OWN_M0;
          dph_state_d = M0_HTRANS[1] ? D_M0 : D_IDLE;
        end
        4'd1: begin
          dph_own_d   = OWN_M1;
          dph_state_d = M1_HTRANS[1] ? D_M1 : D_IDLE;
        end
        default: begin
          dph_own_d   = OWN_NONE;
          dph_state_d = D_IDLE;
        end
      endcase
    end else begin
      dph_state_d   = dph_state_q;
      dph_own_d     = dph_own_q;
      prev_master_d = prev_master_q;
    end
  end

  // Saturating per-master completed-transfer counters; clear beats increment.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (CNT_CLR) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (HREADY && (dph_state_q == D_M0) && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt0_d = cnt0_q;
      end
      if (HREADY && (dph_state_q == D_M1) && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt1_d = cnt1_q;
      end
    end
  end

  // Wait counter saturates so the stall flag fires once per stall episode.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (HREADY) begin
      wait_cnt_d = '0;
    end else if (dph_valid_s && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    stall_set_s = (wait_cnt_d == TIMEOUT_C) && (wait_cnt_q != TIMEOUT_C);
    lock_set_s  = HREADY && HMASTLOCK && (HMASTER != prev_master_q);
    if (stall_set_s) begin
      stall_d = 1'b1;
    end else if (FLAG_CLR) begin
      stall_d = 1'b0;
    end else begin
      stall_d = stall_q;
    end
    if (lock_set_s) begin
      lock_d = 1'b1;
    end else if (FLAG_CLR) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end
  end

  // State registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dph_state_q   <= D_IDLE;
      dph_own_q     <= OWN_NONE;
      prev_master_q <= 4'd0;
      wait_cnt_q    <= '0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      stall_q       <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      dph_state_q   <= dph_state_d;
      dph_own_q     <= dph_own_d;
      prev_master_q <= prev_master_d;
      wait_cnt_q    <= wait_cnt_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      stall_q       <= stall_d;
      lock_q        <= lock_d;
    end
  end

  assign M0_XFER_CNT = cnt0_q;
  assign M1_XFER_CNT = cnt1_q;
  assign STALL_FLAG  = stall_q;
  assign LOCK_VIOL   = lock_q;

endmodule

// File: tb/tb_mipsfpga_ahb_master_mux.sv
// Directed bench for mipsfpga_ahb_master_mux (CNT_W=2, TIMEOUT=4); expectations are queued
// per cycle by the driver and compared by an independent negedge monitor.
module tb_mipsfpga_ahb_master_mux;

  localparam int S_HADDR = 0, S_HTRANS = 1, S_HWRITE = 2, S_HSIZE = 3, S_HBURST = 4;
  localparam int S_HWDATA = 5, S_M0R = 6, S_M1R = 7, S_C0 = 8, S_C1 = 9;
  localparam int S_STALL = 10, S_LOCK = 11;
  localparam logic [31:0] D0 = 32'hAAAA_0000;
  localparam logic [31:0] D1 = 32'hBBBB_0000;

  logic        HCLK, HRESET, HMASTLOCK, HREADY, CNT_CLR, FLAG_CLR;
  logic [3:0]  HMASTER;
  logic [1:0]  HRESP;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS, M0_HRESP, M1_HRESP;
  logic        HWRITE, STALL_FLAG, LOCK_VIOL;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  M0_XFER_CNT, M1_XFER_CNT;

  mipsfpga_ahb_master_mux #(.ADDR_W(32), .DATA_W(32), .CNT_W(2), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRESP(HRESP),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HWDATA(M0_HWDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HWDATA(M1_HWDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .M0_HRESP(M0_HRESP), .M1_HRESP(M1_HRESP),
    .M0_XFER_CNT(M0_XFER_CNT), .M1_XFER_CNT(M1_XFER_CNT), .CNT_CLR(CNT_CLR),
    .STALL_FLAG(STALL_FLAG), .LOCK_VIOL(LOCK_VIOL), .FLAG_CLR(FLAG_CLR)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_HADDR:  return HADDR;
      S_HTRANS: return {30'd0, HTRANS};
      S_HWRITE: return {31'd0, HWRITE};
      S_HSIZE:  return {29'd0, HSIZE};
      S_HBURST: return {29'd0, HBURST};
      S_HWDATA: return HWDATA;
      S_M0R:    return {30'd0, M0_HRESP};
      S_M1R:    return {30'd0, M1_HRESP};
      S_C0:     return {30'd0, M0_XFER_CNT};
      S_C1:     return {30'd0, M1_XFER_CNT};
      S_STALL:  return {31'd0, STALL_FLAG};
      S_LOCK:   return {31'd0, LOCK_VIOL};
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: pops every expectation queued for the current cycle and compares.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge HCLK);
      while (q.size() > 0 && q[0].cyc == cyc) begin
        e   = q.pop_front();
        act = pick(e.sel);
        n_vec = n_vec + 1;
        if (act !== e.val) begin
          n_bad = n_bad + 1;
          $display("FAIL %s (cycle %0d): got %h want %h", e.name, e.cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    HRESET = 1'b1; HMASTER = 4'd0; HMASTLOCK = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
    CNT_CLR = 1'b0; FLAG_CLR = 1'b0;
    M0_HADDR = 32'h100; M0_HTRANS = 2'b10; M0_HWRITE = 1'b1; M0_HSIZE = 3'd2;
    M0_HBURST = 3'd0; M0_HWDATA = D0;
    M1_HADDR = 32'h200; M1_HTRANS = 2'b10; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2;
    M1_HBURST = 3'd1; M1_HWDATA = D1;

    tick();
    chk("rst_hwdata", S_HWDATA, 32'h0); chk("rst_m0resp", S_M0R, 32'h0);
    chk("rst_m1resp", S_M1R, 32'h0);    chk("rst_cnt0", S_C0, 32'h0);
    chk("rst_cnt1", S_C1, 32'h0);       chk("rst_stall", S_STALL, 32'h0);
    chk("rst_lock", S_LOCK, 32'h0);     chk("rst_haddr", S_HADDR, 32'h100);

    // Handover M0 -> M1
    tick(); HRESET = 1'b0;
    chk("ho_haddr0", S_HADDR, 32'h100); chk("ho_htrans0", S_HTRANS, 32'h2);
    chk("ho_hwrite0", S_HWRITE, 32'h1); chk("ho_hwdata_none", S_HWDATA, 32'h0);
    chk("ho_cnt0_a", S_C0, 32'h0);
    tick(); HMASTER = 4'd1; M0_HTRANS = 2'b00;
    chk("ho_haddr1", S_HADDR, 32'h200); chk("ho_hwrite1", S_HWRITE, 32'h0);
    chk("ho_hburst1", S_HBURST, 32'h1); chk("ho_hwdata_m0", S_HWDATA, D0);
    chk("ho_m0resp", S_M0R, 32'h0);     chk("ho_cnt0_b", S_C0, 32'h0);

    // M1 data phase with three wait states
    tick(); M1_HTRANS = 2'b00; HREADY = 1'b0;
    chk("ws_cnt0", S_C0, 32'h1); chk("ws_hwdata1", S_HWDATA, D1); chk("ws_cnt1_a", S_C1, 32'h0);
    tick(); chk("ws_hwdata2", S_HWDATA, D1); chk("ws_cnt1_b", S_C1, 32'h0);
    tick(); chk("ws_cnt1_c", S_C1, 32'h0);
    tick(); HREADY = 1'b1;
    chk("ws_cnt1_d", S_C1, 32'h0); chk("ws_hwdata3", S_HWDATA, D1); chk("ws_stall", S_STALL, 32'h0);
    tick(); HMASTER = 4'd2;
    chk("ws_cnt1_e", S_C1, 32'h1);     chk("nm_htrans", S_HTRANS, 32'h0);
    chk("nm_haddr", S_HADDR, 32'h0);   chk("nm_hwrite", S_HWRITE, 32'h0);
    chk("nm_hsize", S_HSIZE, 32'h0);   chk("nm_hburst", S_HBURST, 32'h0);
    chk("nm_hwdata_m1", S_HWDATA, D1);
    tick(); HMASTER = 4'd0; CNT_CLR = 1'b1;
    chk("nm_hwdata0", S_HWDATA, 32'h0); chk("clr_cnt1_pre", S_C1, 32'h1);

    // Stall watchdog
    tick(); CNT_CLR = 1'b0; M0_HTRANS = 2'b10;
    chk("clr_cnt0", S_C0, 32'h0); chk("clr_cnt1", S_C1, 32'h0); chk("to_hwdata", S_HWDATA, D0);
    tick(); M0_HTRANS = 2'b00; HREADY = 1'b0; chk("to_stall_w0", S_STALL, 32'h0);
    tick(); tick();
    tick(); chk("to_stall_w3", S_STALL, 32'h0);
    tick(); FLAG_CLR = 1'b1; chk("to_stall_set", S_STALL, 32'h1);
    tick(); FLAG_CLR = 1'b0; chk("to_stall_clr", S_STALL, 32'h0);
    tick(); chk("to_stall_stay", S_STALL, 32'h0);
    tick(); HREADY = 1'b1; chk("to_stall_rdy", S_STALL, 32'h0); chk("to_cnt0_pre", S_C0, 32'h0);
    tick(); M0_HTRANS = 2'b10; chk("to_cnt0", S_C0, 32'h1); chk("to_stall_end", S_STALL, 32'h0);

    // Two-cycle ERROR response to M0
    tick(); M0_HTRANS = 2'b00; HRESP = 2'b01; HREADY = 1'b0;
    chk("err_m0_c1", S_M0R, 32'h1); chk("err_m1_c1", S_M1R, 32'h0);
    tick(); HREADY = 1'b1;
    chk("err_m0_c2", S_M0R, 32'h1); chk("err_m1_c2", S_M1R, 32'h0);
    tick();
    chk("err_m0_idle", S_M0R, 32'h0); chk("err_m1_idle", S_M1R, 32'h0); chk("err_cnt0", S_C0, 32'h2);

    // Lock violation
    tick(); HRESP = 2'b00; HMASTLOCK = 1'b1; chk("lk_same", S_LOCK, 32'h0);
    tick(); HMASTER = 4'd1; chk("lk_pre", S_LOCK, 32'h0);
    tick(); HMASTLOCK = 1'b0; FLAG_CLR = 1'b1; chk("lk_set", S_LOCK, 32'h1);
    tick(); FLAG_CLR = 1'b0; HMASTER = 4'd0; chk("lk_clr", S_LOCK, 32'h0);
    tick(); HMASTER = 4'd1; chk("lk_unlocked_a", S_LOCK, 32'h0);
    tick(); HMASTLOCK = 1'b1; HMASTER = 4'd0; FLAG_CLR = 1'b1; chk("lk_unlocked_b", S_LOCK, 32'h0);
    tick(); HMASTLOCK = 1'b0; FLAG_CLR = 1'b0; chk("lk_set_wins", S_LOCK, 32'h1);

    // Counter saturation and mid-transfer reset
    tick(); CNT_CLR = 1'b1; M0_HTRANS = 2'b10; chk("sat_pre", S_C0, 32'h2);
    tick(); CNT_CLR = 1'b0; chk("sat_c0", S_C0, 32'h0);
    tick(); chk("sat_c1", S_C0, 32'h1);
    tick(); chk("sat_c2", S_C0, 32'h2);
    tick(); chk("sat_c3", S_C0, 32'h3);
    tick(); chk("sat_c4", S_C0, 32'h3);
    tick(); HREADY = 1'b0;
    chk("sat_c5", S_C0, 32'h3); chk("sat_hwdata", S_HWDATA, D0); chk("sat_lock", S_LOCK, 32'h1);
    tick(); HRESET = 1'b1; HRESP = 2'b01;
    chk("mr_cnt0", S_C0, 32'h0);      chk("mr_cnt1", S_C1, 32'h0);
    chk("mr_lock", S_LOCK, 32'h0);    chk("mr_stall", S_STALL, 32'h0);
    chk("mr_hwdata", S_HWDATA, 32'h0); chk("mr_m0resp", S_M0R, 32'h0);
    chk("mr_haddr", S_HADDR, 32'h100);
    tick(); HRESET = 1'b0; HRESP = 2'b00; HREADY = 1'b1; HMASTER = 4'd2;
    chk("mr_cnt0_after", S_C0, 32'h0); chk("mr_hwdata_after", S_HWDATA, 32'h0);
    tick(); chk("mr_no_count", S_C0, 32'h0);

    tick(); tick();
    if (q.size() != 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL leftover: got %0d unchecked entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mipsfpga_ahb_master_mux.md
Name: mipsfpga_ahb_master_mux

Overview:
Shares the single AHB-Lite bus between CPU0 and CPU1 under control of the two-master arbiter's HMASTER output. It muxes address/control by address-phase owner and HWDATA by data-phase owner, and routes HRESP only to the data-phase owner. It also tracks per-master completed transfers and flags stalled data phases and lock violations. It sits between the two master ports, the arbiter and the slave decoder/mux.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, write-data width
- CNT_W, 16, per-master transfer counter width
- TIMEOUT, 255, consecutive wait-state cycles before the stall flag sets (1..2^12-1)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- HMASTER  in  4  address-phase owner from arbiter; 0=CPU0, 1=CPU1, other=none
- HMASTLOCK  in  1  locked-sequence indication from arbiter
- HREADY  in  1  bus ready from slave mux
- HRESP  in  2  slave response (bit0 used: 0 OKAY, 1 ERROR)
- M0_HADDR/M1_HADDR  in  ADDR_W  master address
- M0_HTRANS/M1_HTRANS  in  2  master transfer type
- M0_HWRITE/M1_HWRITE  in  1  master write
- M0_HSIZE/M1_HSIZE  in  3  master size
- M0_HBURST/M1_HBURST  in  3  master burst
- M0_HWDATA/M1_HWDATA  in  DATA_W  master write data
- HADDR, HTRANS, HWRITE, HSIZE, HBURST  out  as above  muxed bus address/control
- HWDATA  out  DATA_W  muxed write data
- M0_HRESP/M1_HRESP  out  2  per-master response
- M0_XFER_CNT/M1_XFER_CNT  out  CNT_W  completed transfers per master
- CNT_CLR  in  1  synchronous clear of both counters
- STALL_FLAG  out  1  sticky: data phase exceeded TIMEOUT wait states
- LOCK_VIOL  out  1  sticky: HMASTER changed while HMASTLOCK high
- FLAG_CLR  in  1  synchronous clear of both sticky flags

Behaviour:
- Address mux is combinational on HMASTER.
  - HMASTER=0 selects M0_*; HMASTER=1 selects M1_*.
  - Any other value drives HTRANS=IDLE(00), HADDR=0, HWRITE=0, HSIZE=0, HBURST=0 (default master).
- Registered state, all loaded only when HREADY=1:
  - dph_master <= HMASTER[0], or the "none" encoding if HMASTER>1.
  - dph_valid <= selected HTRANS[1] (NONSEQ/SEQ = 1, IDLE/BUSY = 0).
  - prev_master <= HMASTER.
- HWDATA = M{dph_master}_HWDATA; HWDATA = 0 when dph_master = none.
- HRESP routing:
  - Data-phase owner's Mx_HRESP = HRESP while dph_valid.
  - The other master's HRESP, and both when dph_valid=0, = OKAY(00).
- Transfer counters:
  - Mx_XFER_CNT increments when HREADY=1 & dph_valid & dph_master=x.
  - Saturates at 2^CNT_W-1; no wrap.
  - CNT_CLR has priority over increment; the counter reads 0 next cycle.
- Stall watchdog:
  - wait_cnt increments each cycle with dph_valid=1 & HREADY=0; resets to 0 on HREADY=1.
  - When wait_cnt reaches TIMEOUT, STALL_FLAG <= 1.
  - The flag is sticky; it is not set again until wait_cnt restarts from 0.
- Lock check: LOCK_VIOL <= 1 when HREADY=1 & HMASTLOCK=1 & HMASTER != prev_master.
- Flag clear: FLAG_CLR clears both flags; a set condition in the same cycle wins (flag stays 1).
- Data-phase tracker FSM (encoded by dph_valid/dph_master):
  - States: D_IDLE, D_M0, D_M1.
  - On HREADY=1, next state = D_M0/D_M1 if the selected HTRANS is active, else D_IDLE.
  - With HREADY=0 the state holds.
- ERROR response: the owner sees ERROR for both cycles of the two-cycle response. The mux does not cancel transfers; the master drives IDLE itself.
- Reset (asynchronous, HRESET=1): dph_valid=0, dph_master=none, prev_master=0, wait_cnt=0, counters=0, STALL_FLAG=0, LOCK_VIOL=0.
  - Outputs after reset: HWDATA=0, both Mx_HRESP=00; address outputs follow HMASTER combinationally.
  - Reset mid-burst abandons the data phase with no count.
- Latency: address/control 0 cycles; HWDATA ownership switches 1 HREADY-qualified cycle after HMASTER.

Test Plan:
- Handover: HMASTER=0 with M0 NONSEQ A=0x100 write, HREADY=1, then HMASTER=1 with M1 NONSEQ 0x200 -> next cycle HADDR=0x200 and HWDATA=M0_HWDATA; M0_XFER_CNT=1 one cycle later.
- Wait states: M1 in data phase, HREADY=0 for 3 cycles -> HWDATA holds M1 data and no count; the count increments only on the HREADY=1 cycle.
- Timeout: TIMEOUT=4, dph_valid with HREADY=0 for 4 cycles -> STALL_FLAG=1; FLAG_CLR -> 0 and it stays 0 while the stall continues.
- Error routing: M0 owns the data phase, HRESP=01 for 2 cycles -> M0_HRESP=01, M1_HRESP=00.
- Lock violation: HMASTLOCK=1, HMASTER 0->1 with HREADY=1 -> LOCK_VIOL=1; the same sequence with HMASTLOCK=0 -> 0.
- Saturation/reset: CNT_W=2, 5 M0 transfers -> M0_XFER_CNT=3; assert HRESET mid-transfer -> all counters, flags and HWDATA at 0 immediately.
